// File: rtl/avalon_mm_arbiter.sv
// rtl/avalon_mm_arbiter.sv - round-robin Avalon-MM arbiter with read-owner tag FIFO
module avalon_mm_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]    m_address_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]    m_writedata_i,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0]  m_byteenable_i,
    input  logic [N_MASTERS-1:0]               m_write_i,
    input  logic [N_MASTERS-1:0]               m_read_i,
    output logic [N_MASTERS-1:0]               m_waitrequest_o,
    output logic [DATA_WIDTH-1:0]              m_readdata_o,
    output logic [N_MASTERS-1:0]               m_readdatavalid_o,
    output logic [ADDR_WIDTH-1:0]              s_address_o,
    output logic [DATA_WIDTH-1:0]              s_writedata_o,
    output logic [DATA_WIDTH/8-1:0]            s_byteenable_o,
    output logic                               s_write_o,
    output logic                               s_read_o,
    input  logic                               s_waitrequest_i,
    input  logic [DATA_WIDTH-1:0]              s_readdata_i,
    input  logic                               s_readdatavalid_i,
    output logic                               err_o
);
    localparam int IDXW = $clog2(N_MASTERS);
    localparam int BEW  = DATA_WIDTH / 8;
    localparam int PW   = $clog2(MAX_PENDING);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_nxt;
    logic [IDXW-1:0]       last, owner, winner, sel;
    logic [N_MASTERS-1:0]  req, elig;
    logic                  found, grant, cmd_rd, cmd_wr, accept;
    logic                  push, pop, fifo_full, fifo_empty, read_block;
    logic [IDXW-1:0]       tag_mem [MAX_PENDING];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    assign req        = m_read_i | m_write_i;
    assign fifo_full  = (count == (PW+1)'(MAX_PENDING));
    assign fifo_empty = (count == '0);
    // a pop in this cycle frees a slot, so a read may be accepted alongside it
    assign read_block = fifo_full & ~s_readdatavalid_i;
    assign elig       = req & ~({N_MASTERS{read_block}} & m_read_i);

    always_comb begin : scan
        int j;
        j      = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            j = int'(last) + k;
            if (j >= N_MASTERS) j = j - N_MASTERS;
            if (!found && elig[j]) begin
                found  = 1'b1;
                winner = IDXW'(j);
            end
        end
    end

    assign sel    = (state == LOCKED) ? owner : winner;
    assign grant  = (state == LOCKED) | found;
    assign cmd_rd = grant & m_read_i[sel];
    assign cmd_wr = grant & m_write_i[sel];
    assign accept = (cmd_rd | cmd_wr) & ~s_waitrequest_i;
    assign push   = accept & cmd_rd;
    assign pop    = s_readdatavalid_i & ~fifo_empty;

    assign s_read_o       = cmd_rd;
    assign s_write_o      = cmd_wr;
    assign s_address_o    = m_address_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_writedata_o  = m_writedata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign s_byteenable_o = m_byteenable_i[int'(sel)*BEW +: BEW];
    assign m_readdata_o   = s_readdata_i;

    always_comb begin
        m_waitrequest_o = '1;
        if (grant) m_waitrequest_o[sel] = s_waitrequest_i;
    end

    always_comb begin
        m_readdatavalid_o = '0;
        if (pop) m_readdatavalid_o[tag_mem[rd_ptr]] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if ((cmd_rd | cmd_wr) && s_waitrequest_i) state_nxt = LOCKED;
            LOCKED:  if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            owner <= '0;
            last  <= IDXW'(N_MASTERS - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == LOCKED) owner <= winner;
            if (accept) last <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (s_readdatavalid_i && fifo_empty) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr] <= sel;
    end
endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// tb/tb_avalon_mm_arbiter.sv - self-checking bench for avalon_mm_arbiter
module tb_avalon_mm_arbiter;
    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [31:0] m_address_i;
    logic [31:0] m_writedata_i;
    logic [3:0]  m_byteenable_i;
    logic [1:0]  m_write_i, m_read_i;
    logic [1:0]  m_waitrequest_o, m_readdatavalid_o;
    logic [15:0] m_readdata_o;
    logic [15:0] s_address_o, s_writedata_o;
    logic [1:0]  s_byteenable_o;
    logic        s_write_o, s_read_o, s_waitrequest_i, s_readdatavalid_i, err_o;
    logic [15:0] s_readdata_i;

    typedef struct {
        logic [1:0]  rdv;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    avalon_mm_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .m_address_i(m_address_i), .m_writedata_i(m_writedata_i),
        .m_byteenable_i(m_byteenable_i), .m_write_i(m_write_i), .m_read_i(m_read_i),
        .m_waitrequest_o(m_waitrequest_o), .m_readdata_o(m_readdata_o),
        .m_readdatavalid_o(m_readdatavalid_o),
        .s_address_o(s_address_o), .s_writedata_o(s_writedata_o),
        .s_byteenable_o(s_byteenable_o), .s_write_o(s_write_o), .s_read_o(s_read_o),
        .s_waitrequest_i(s_waitrequest_i), .s_readdata_i(s_readdata_i),
        .s_readdatavalid_i(s_readdatavalid_i), .err_o(err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_address_i       = '0;
        m_writedata_i     = '0;
        m_byteenable_i    = '0;
        m_write_i         = '0;
        m_read_i          = '0;
        s_waitrequest_i   = 1'b0;
        s_readdata_i      = '0;
        s_readdatavalid_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        exp_q.delete();
    endtask

    task automatic issue_reads(input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            m_read_i[k%2] = 1'b1;
            m_address_i   = {16'h0700 + 16'(k), 16'h0700 + 16'(k)};
            @(negedge clk);
            n_cmp++;
            if (s_read_o !== 1'b1 || m_waitrequest_o !== ~(2'b01 << (k%2))) begin
                n_bad++;
                $display("FAIL issue_read%0d: s_read=%b wait=%b, want 1 / %b", k, s_read_o,
                         m_waitrequest_o, ~(2'b01 << (k%2)));
            end
            exp_q.push_back('{rdv: 2'b01 << (k%2), data: base + 16'(k)});
            step();
        end
        idle_inputs();
    endtask

    task automatic return_read(input logic [15:0] data);
        exp_t e;
        s_readdatavalid_i = 1'b1;
        s_readdata_i      = data;
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL return_read: scoreboard empty, rdv=%b", m_readdatavalid_o);
        end else begin
            e = exp_q.pop_front();
            if (m_readdatavalid_o !== e.rdv || m_readdata_o !== e.data) begin
                n_bad++;
                $display("FAIL return_read: rdv=%b data=%h, want rdv=%b data=%h",
                         m_readdatavalid_o, m_readdata_o, e.rdv, e.data);
            end
        end
        step();
        s_readdatavalid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_read_o !== 1'b0 || s_write_o !== 1'b0 || m_waitrequest_o !== 2'b11 ||
            m_readdatavalid_o !== 2'b00 || err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: rd=%b wr=%b wait=%b rdv=%b err=%b, want 0 0 11 00 0",
                     s_read_o, s_write_o, m_waitrequest_o, m_readdatavalid_o, err_o);
        end
        step();
        rst_n_i = 1'b1;
    endtask

    task automatic test_write();
        do_reset();
        m_write_i      = 2'b01;
        m_address_i    = {16'h0000, 16'h0010};
        m_writedata_i  = {16'h0000, 16'hBEEF};
        m_byteenable_i = 4'b0011;
        @(negedge clk);
        n_cmp++;
        if (s_write_o !== 1'b1 || s_read_o !== 1'b0 || s_address_o !== 16'h0010 ||
            s_writedata_o !== 16'hBEEF || s_byteenable_o !== 2'b11 || m_waitrequest_o !== 2'b10) begin
            n_bad++;
            $display("FAIL write: wr=%b rd=%b addr=%h data=%h be=%b wait=%b, want 1 0 0010 beef 11 10",
                     s_write_o, s_read_o, s_address_o, s_writedata_o, s_byteenable_o, m_waitrequest_o);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        m_write_i   = 2'b11;
        m_address_i = {16'h0200, 16'h0100};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (s_address_o !== ((i%2 == 1) ? 16'h0200 : 16'h0100) ||
                m_waitrequest_o !== ((i%2 == 1) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL round_robin%0d: addr=%h wait=%b, want master %0d", i,
                         s_address_o, m_waitrequest_o, i%2);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        m_read_i    = 2'b10;
        m_address_i = {16'h0300, 16'h0400};
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) m_write_i = 2'b01;
            s_waitrequest_i = (c < 3);
            @(negedge clk);
            n_cmp++;
            if (s_read_o !== 1'b1 || s_write_o !== 1'b0 || s_address_o !== 16'h0300 ||
                m_waitrequest_o !== ((c < 3) ? 2'b11 : 2'b01)) begin
                n_bad++;
                $display("FAIL lock%0d: rd=%b wr=%b addr=%h wait=%b, want m1 held", c,
                         s_read_o, s_write_o, s_address_o, m_waitrequest_o);
            end
            if (c == 3) exp_q.push_back('{rdv: 2'b10, data: 16'hA5A5});
            step();
        end
        m_read_i        = 2'b00;
        s_waitrequest_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_write_o !== 1'b1 || s_address_o !== 16'h0400 || m_waitrequest_o !== 2'b10) begin
            n_bad++;
            $display("FAIL lock_release: wr=%b addr=%h wait=%b, want 1 0400 10",
                     s_write_o, s_address_o, m_waitrequest_o);
        end
        step();
        idle_inputs();
        return_read(16'hA5A5);
    endtask

    task automatic test_pipelined_reads();
        do_reset();
        issue_reads(16'h1111);
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{rdv: 2'b01 << (k%2), data: 16'(16'h1111 * (k + 1))});
        step();
        for (int k = 0; k < 4; k++) return_read(16'(16'h1111 * (k + 1)));
    endtask

    task automatic test_fifo_full();
        exp_t e;
        do_reset();
        issue_reads(16'h0A01);
        m_read_i    = 2'b01;
        m_address_i = {16'h0600, 16'h0500};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (s_read_o !== 1'b0 || m_waitrequest_o !== 2'b11) begin
                n_bad++;
                $display("FAIL full_block%0d: rd=%b wait=%b, want 0 11", c, s_read_o, m_waitrequest_o);
            end
            step();
        end
        m_write_i = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (s_write_o !== 1'b1 || s_read_o !== 1'b0 || s_address_o !== 16'h0600 ||
            m_waitrequest_o !== 2'b01) begin
            n_bad++;
            $display("FAIL full_write: wr=%b rd=%b addr=%h wait=%b, want 1 0 0600 01",
                     s_write_o, s_read_o, s_address_o, m_waitrequest_o);
        end
        step();
        m_write_i         = 2'b00;
        s_readdatavalid_i = 1'b1;
        s_readdata_i      = 16'h0A01;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (s_read_o !== 1'b1 || s_address_o !== 16'h0500 || m_waitrequest_o !== 2'b10 ||
            m_readdatavalid_o !== e.rdv || m_readdata_o !== e.data) begin
            n_bad++;
            $display("FAIL full_pushpop: rd=%b addr=%h wait=%b rdv=%b data=%h, want 1 0500 10 %b %h",
                     s_read_o, s_address_o, m_waitrequest_o, m_readdatavalid_o, m_readdata_o,
                     e.rdv, e.data);
        end
        exp_q.push_back('{rdv: 2'b01, data: 16'h0A05});
        step();
        idle_inputs();
        for (int k = 2; k <= 5; k++) return_read(16'h0A00 + 16'(k));
    endtask

    task automatic test_err();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_initial: err=%b want 0", err_o);
        end
        step();
        s_readdatavalid_i = 1'b1;
        s_readdata_i      = 16'hDEAD;
        @(negedge clk);
        n_cmp++;
        if (m_readdatavalid_o !== 2'b00) begin
            n_bad++;
            $display("FAIL err_no_strobe: rdv=%b want 00", m_readdatavalid_o);
        end
        step();
        s_readdatavalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (err_o !== 1'b1) begin
                n_bad++;
                $display("FAIL err_sticky%0d: err=%b want 1", c, err_o);
            end
            step();
        end
        rst_n_i = 1'b0;
        #2;
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_cleared: err=%b want 0", err_o);
        end
        step();
        rst_n_i = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n_i = 1'b0;
        step();
        test_reset();
        test_write();
        test_round_robin();
        test_lock();
        test_pipelined_reads();
        test_fifo_full();
        test_err();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
